cpu_seq: RTL and testbench

- Instruction sequencer in front of the 16-bit base processor (mv/mvi/add/sub, R0-R7).
- Holds a small loadable program buffer and, on start, issues each instruction over the processor's run/din/done interface.
- Inserts the mvi immediate word and waits for done before the next issue.
- Replaces hand-driven run/din stimulus; also usable as a boot sequencer.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/cpu_seq_prog_buf.sv | 23 ++
 rtl/cpu_seq.sv | 165 ++++++++++++++++
 tb/tb_cpu_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_seq instruction sequencer: opcodes,
// register codes, instruction field layout, error codes and FSM states.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6, R7} reg_t;

  // Instruction word = {7'b0, op[2:0], rx[2:0], ry[2:0]}
  localparam int INSTR_W = 16;
  localparam int FIELD_W = 3;
  localparam int OP_LSB  = 6;
  localparam int RX_LSB  = 3;
  localparam int RY_LSB  = 0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_NO_IMM  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_IMM, S_WAIT, S_FIN, S_ERR
  } state_t;

  function automatic logic [FIELD_W-1:0] instr_op(input logic [INSTR_W-1:0] w);
    return w[OP_LSB +: FIELD_W];
  endfunction

  // Opcodes 100..110 are reserved; HALT is legal but never issued.
  function automatic logic op_legal(input logic [FIELD_W-1:0] op);
    return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_HALT);
  endfunction

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [FIELD_W-1:0] op,
                                                  input logic [FIELD_W-1:0] rx,
                                                  input logic [FIELD_W-1:0] ry);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: FIELD_W] = op;
    w[RX_LSB +: FIELD_W] = rx;
    w[RY_LSB +: FIELD_W] = ry;
    return w;
  endfunction

endpackage

// File: rtl/cpu_seq_prog_buf.sv
// Program buffer: DEPTH x 16 storage, one write port, registered read port.
// Contents are not reset; the write pointer lives in the sequencer.
module prog_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [15:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [15:0]              rdata
);
  import cpu_pkg::*;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write on demand, read every cycle with one cycle of latency.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_seq.sv
// Instruction sequencer: holds a loaded program and issues it to the base
// processor over run/din/done, inserting mvi immediates and waiting for done.
module cpu_seq #(
  parameter int DEPTH = 16,
  parameter int TMO   = 15
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [15:0]              ld_data,
  input  logic                     ld_clr,
  input  logic                     start,
  output logic                     busy,
  output logic                     fin,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic [7:0]               icnt,
  output logic                     cpu_run,
  output logic [15:0]              cpu_din,
  input  logic                     cpu_done
);
  import cpu_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t         state;
  logic [PW-1:0]  wptr;
  logic           rdy_en;
  logic           full;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic [15:0]    rd_data;
  logic [PW-1:0]  pc_ext;
  logic [PW-1:0]  pc_inc_ext;
  logic [2:0]     op;
  logic [7:0]     tmr;

  assign full       = (wptr == PW'(DEPTH));
  assign busy       = (state != S_IDLE);
  // rdy_en keeps ld_ready low until the first clock after reset release.
  assign ld_ready   = rdy_en && !busy && !full;
  assign wr_en      = ld_valid && ld_ready && !ld_clr;
  assign wr_addr    = wptr[AW-1:0];
  // ISSUE pre-reads the word after the instruction so IMM has the immediate.
  assign rd_addr    = (state == S_ISSUE) ? pc + AW'(1) : pc;
  assign pc_ext     = {1'b0, pc};
  assign pc_inc_ext = pc_ext + PW'(1);
  assign op         = instr_op(rd_data);

  prog_buf #(.DEPTH(DEPTH)) u_buf (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (ld_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Write pointer: clear (IDLE only) beats a same-cycle load.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr   <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (ld_clr && !busy) wptr <= '0;
      else if (wr_en)      wptr <= wptr + PW'(1);
    end
  end

  // Sequencer FSM with registered processor-side and status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      pc       <= '0;
      icnt     <= '0;
      fin      <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      cpu_run  <= 1'b0;
      cpu_din  <= '0;
      tmr      <= '0;
    end else begin
      fin     <= 1'b0;
      cpu_run <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc       <= '0;
            icnt     <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            if (wptr == '0) begin
              fin   <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: state <= S_ISSUE;
        S_ISSUE: begin
          tmr <= '0;
          if (op == OP_HALT || pc_ext == wptr) begin
            fin   <= 1'b1;
            state <= S_FIN;
          end else if (!op_legal(op)) begin
            err      <= 1'b1;
            err_code <= ERR_ILLEGAL;
            state    <= S_ERR;
          end else begin
            cpu_run <= 1'b1;
            cpu_din <= rd_data;
            if (op == OP_MVI) begin
              // The run pulse still goes out; the processor is reset anyway
              // before the next program if the immediate is missing.
              if (pc_inc_ext == wptr) begin
                err      <= 1'b1;
                err_code <= ERR_NO_IMM;
                state    <= S_ERR;
              end else begin
                state <= S_IMM;
              end
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_IMM: begin
          cpu_din <= rd_data;
          pc      <= pc + AW'(1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (cpu_done) begin
            if (icnt != 8'hFF) icnt <= icnt + 8'd1;
            // pc stays on the last instruction when the program runs out.
            if (pc_inc_ext == wptr) begin
              fin   <= 1'b1;
              state <= S_FIN;
            end else begin
              pc    <= pc + AW'(1);
              state <= S_FETCH;
            end
          end else if (tmr == TMO_LAST) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= S_ERR;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: directed table, hand-written corner sequences and
// randomized programs checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_cpu_seq;
  import cpu_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 15;
  localparam int AW    = $clog2(DEPTH);

  logic clock = 1'b0, resetn = 1'b0;
  logic ld_valid = 1'b0, ld_clr = 1'b0, start = 1'b0;
  logic [15:0] ld_data = 16'h0;
  logic ld_ready, busy, fin, err, cpu_run;
  logic [1:0] err_code;
  logic [AW-1:0] pc;
  logic [7:0] icnt;
  logic [15:0] cpu_din;
  logic cpu_done;
  logic proc_done = 1'b0, ext_done = 1'b0;
  assign cpu_done = proc_done | ext_done;

  cpu_seq #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .clock(clock), .resetn(resetn), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_clr(ld_clr), .start(start), .busy(busy), .fin(fin),
    .err(err), .err_code(err_code), .pc(pc), .icnt(icnt), .cpu_run(cpu_run),
    .cpu_din(cpu_din), .cpu_done(cpu_done)
  );

  initial forever #5 clock = ~clock;

  int nchk = 0, nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- processor model ----------------
  logic [15:0] regs [8];
  int   done_lat = 3;
  logic done_en  = 1'b1;
  logic reg_init = 1'b0;

  initial begin : proc_model
    int cnt;
    logic pend;
    logic [2:0] rxi;
    cnt = 0; pend = 1'b0; rxi = 3'd0;
    forever begin
      @(posedge clock); #1;
      proc_done = 1'b0;
      if (!resetn) begin
        cnt = 0; pend = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && done_en) proc_done = 1'b1;
        end
        if (pend) begin regs[rxi] = cpu_din; pend = 1'b0; end
        if (cpu_run) begin
          rxi = cpu_din[5:3];
          case (cpu_din[8:6])
            3'b000:  regs[rxi] = regs[cpu_din[2:0]];
            3'b001:  pend = 1'b1;
            3'b010:  regs[rxi] = regs[rxi] + regs[cpu_din[2:0]];
            3'b011:  regs[rxi] = regs[rxi] - regs[cpu_din[2:0]];
            default: ;
          endcase
          cnt = done_lat;
        end
      end
      if (reg_init) for (int i = 0; i < 8; i++) regs[i] = 16'(i);
    end
  end

  // ---------------- bus monitor ----------------
  logic [15:0] obs [$];
  int fin_cnt = 0, run_cnt = 0, multi = 0;
  logic mon_clr = 1'b0;

  initial begin : monitor
    logic prev_run, prev_mvi;
    prev_run = 1'b0; prev_mvi = 1'b0;
    forever begin
      @(posedge clock); #2;
      if (mon_clr) begin
        obs.delete(); fin_cnt = 0; run_cnt = 0; multi = 0; prev_mvi = 1'b0;
      end
      if (fin) fin_cnt++;
      if (cpu_run) begin
        obs.push_back(cpu_din);
        run_cnt++;
        if (prev_run) multi++;
        prev_mvi = (cpu_din[8:6] == 3'b001);
      end else if (prev_mvi) begin
        obs.push_back(cpu_din);
        prev_mvi = 1'b0;
      end
      prev_run = cpu_run;
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] prog [DEPTH];
  logic [15:0] exp_q [$];
  int e_icnt, e_pc, e_err, e_code, e_fin, e_nrun;

  // Walk the program instruction by instruction; the expected din stream is
  // each issued word followed by its immediate (or the held word if absent).
  task automatic model(input int n);
    int p;
    logic [2:0] opc;
    exp_q.delete();
    e_icnt = 0; e_pc = 0; e_err = 0; e_code = 0; e_fin = 0; e_nrun = 0;
    if (n == 0) begin e_fin = 1; return; end
    p = 0;
    while (1) begin
      opc = prog[p][8:6];
      if (opc == 3'b111) begin e_fin = 1; break; end
      if (opc >= 3'b100) begin e_err = 1; e_code = 1; break; end
      exp_q.push_back(prog[p]);
      e_nrun++;
      if (opc == 3'b001) begin
        if (p + 1 == n) begin exp_q.push_back(prog[p]); e_err = 1; e_code = 3; break; end
        p++;
        exp_q.push_back(prog[p]);
      end
      e_icnt++;
      if (p + 1 == n) begin e_fin = 1; break; end
      p++;
    end
    e_pc = p;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic prep();
    reg_init = 1'b1; mon_clr = 1'b1;
    @(negedge clock);
    reg_init = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic load(input int n);
    ld_clr = 1'b1;
    @(negedge clock);
    ld_clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_data = prog[i];
      @(negedge clock);
    end
    ld_valid = 1'b0;
  endtask

  task automatic go(input string tag, input int poke);
    int cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 3000) begin
      start = (cyc == poke);
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_idle_reached"}, int'(busy), 0);
    repeat (8) @(negedge clock);
  endtask

  task automatic cmp_model(input string tag);
    int nbad;
    chk({tag, "_icnt"}, icnt, e_icnt);
    chk({tag, "_pc"}, pc, e_pc);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_code"}, err_code, e_code);
    chk({tag, "_fin"}, fin_cnt, e_fin);
    chk({tag, "_nrun"}, run_cnt, e_nrun);
    chk({tag, "_runwide"}, multi, 0);
    chk({tag, "_nwords"}, obs.size(), exp_q.size());
    nbad = 0;
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      if (obs[i] !== exp_q[i]) nbad++;
    chk({tag, "_din_bad"}, nbad, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0][15:0] w;
    int n, icnt, pc, err, code, fin, nrun, ra, va, rb, vb;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3, input int n,
                              input int ic, p, e, c, f, nr, ra, va, rb, vb);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.n = n; v.icnt = ic; v.pc = p; v.err = e; v.code = c; v.fin = f; v.nrun = nr;
    v.ra = ra; v.va = va; v.rb = rb; v.vb = vb;
    return v;
  endfunction

  vec_t tbl [8];

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc, n;
    string tag;

    tbl[0] = mk(16'h0001, 16'h0093, 16'h00FE, 16'h0, 3, 3, 2, 0, 0, 1, 3, 2, 5, 7, 1);
    tbl[1] = mk(16'h0040, 16'h000F, 16'h0, 16'h0, 2, 1, 1, 0, 0, 1, 1, 0, 15, 1, 1);
    tbl[2] = mk(16'h0001, 16'h01C0, 16'h0093, 16'h0, 3, 1, 1, 0, 0, 1, 1, 2, 2, 0, 1);
    tbl[3] = mk(16'h0100, 16'h0, 16'h0, 16'h0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    tbl[4] = mk(16'h0001, 16'h0, 16'h0, 16'h0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1);
    tbl[5] = mk(16'h0093, 16'h0040, 16'h0, 16'h0, 2, 1, 1, 1, 3, 0, 2, 2, 5, 3, 3);
    tbl[6] = mk(16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    tbl[7] = mk(16'h0001, 16'h0180, 16'h0, 16'h0, 2, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1);

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_fin", fin, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_icnt", icnt, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_cpu_din", cpu_din, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_ld_ready", ld_ready, 1);

    // Directed table
    for (int t = 0; t < 8; t++) begin
      tag = $sformatf("tbl%0d", t);
      for (int i = 0; i < 4; i++) prog[i] = tbl[t].w[i];
      done_en = 1'b1; done_lat = 3;
      load(tbl[t].n);
      prep();
      model(tbl[t].n);
      go(tag, -1);
      chk({tag, "_icnt_tbl"}, icnt, tbl[t].icnt);
      chk({tag, "_pc_tbl"}, pc, tbl[t].pc);
      chk({tag, "_err_tbl"}, err, tbl[t].err);
      chk({tag, "_code_tbl"}, err_code, tbl[t].code);
      chk({tag, "_fin_tbl"}, fin_cnt, tbl[t].fin);
      chk({tag, "_nrun_tbl"}, run_cnt, tbl[t].nrun);
      chk({tag, "_rega"}, regs[tbl[t].ra], tbl[t].va);
      chk({tag, "_regb"}, regs[tbl[t].rb], tbl[t].vb);
      cmp_model(tag);
    end

    // Start while busy is ignored
    prog[0] = 16'h0001; prog[1] = 16'h0093; prog[2] = 16'h00FE;
    load(3); prep(); go("busy_start", 4);
    chk("busy_start_fin", fin_cnt, 1);
    chk("busy_start_icnt", icnt, 3);
    chk("busy_start_nrun", run_cnt, 3);

    // cpu_done outside WAIT is ignored
    ext_done = 1'b1;
    @(negedge clock);
    ext_done = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_done_icnt", icnt, 3);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_pc", pc, 2);

    // Done timeout
    done_en = 1'b0;
    prog[0] = 16'h0001;
    load(1); prep();
    start = 1'b1; @(negedge clock); start = 1'b0;
    cyc = 0;
    while (!cpu_run && cyc < 20) begin @(negedge clock); cyc++; end
    chk("tmo_run_seen", cpu_run, 1);
    cyc = 0;
    while (!err && cyc < 100) begin @(negedge clock); cyc++; end
    chk("tmo_cycles", cyc, TMO);
    chk("tmo_code", err_code, 2);
    chk("tmo_pc", pc, 0);
    chk("tmo_icnt", icnt, 0);
    repeat (3) @(negedge clock);
    chk("tmo_idle", busy, 0);
    done_en = 1'b1;

    // Full buffer: 17th word dropped, DEPTH-word program runs fully
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'h0000;
    load(DEPTH);
    chk("full_ld_ready", ld_ready, 0);
    ld_valid = 1'b1; ld_data = 16'h0100;
    @(negedge clock);
    ld_valid = 1'b0;
    prep(); go("full", -1);
    chk("full_icnt", icnt, DEPTH);
    chk("full_pc", pc, DEPTH - 1);
    chk("full_err", err, 0);
    chk("full_fin", fin_cnt, 1);
    chk("full_nrun", run_cnt, DEPTH);

    // Reset asserted while the run pulse is out
    done_en = 1'b0;
    prog[0] = 16'h0001;
    load(1); prep();
    start = 1'b1; @(negedge clock); start = 1'b0;
    cyc = 0;
    while (!cpu_run && cyc < 20) begin @(negedge clock); cyc++; end
    chk("mid_run_seen", cpu_run, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_cpu_run", cpu_run, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ld_ready", ld_ready, 0);
    @(negedge clock);
    resetn = 1'b1;
    done_en = 1'b1;
    repeat (2) @(negedge clock);
    prep(); go("after_rst", -1);
    chk("after_rst_fin", fin_cnt, 1);
    chk("after_rst_nrun", run_cnt, 0);
    chk("after_rst_icnt", icnt, 0);

    // Randomized programs against the reference model
    for (int r = 0; r < 40; r++) begin
      int i, rr;
      logic [2:0] opc;
      n = $urandom_range(0, DEPTH);
      i = 0;
      while (i < n) begin
        rr = $urandom_range(0, 99);
        if (rr < 22)      opc = 3'b000;
        else if (rr < 44) opc = 3'b001;
        else if (rr < 66) opc = 3'b010;
        else if (rr < 88) opc = 3'b011;
        else if (rr < 94) opc = 3'b111;
        else              opc = 3'(4 + $urandom_range(0, 2));
        prog[i] = mk_instr(opc, 3'($urandom), 3'($urandom));
        i++;
        if (opc == 3'b001 && i < n) begin prog[i] = 16'($urandom); i++; end
      end
      done_lat = $urandom_range(1, 6);
      load(n); prep(); model(n);
      tag = $sformatf("rnd%0d", r);
      go(tag, -1);
      cmp_model(tag);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
